// File: rtl/puf_serial_vote.sv
// -----------------------------------------------------------------------------
// puf_serial_vote
//
// Ring-oscillator PUF with serial majority voting. For every response bit an
// LFSR picks one oscillator from bank A and one from bank B. Both are enabled,
// their rising edges are counted over a fixed window, and the faster
// oscillator decides the vote. VOTES comparisons are made per bit, and the
// majority becomes the bit. After RESP_W bits the response is presented with
// valid until the consumer acknowledges it.
//
// Ports
//   clock      : system clock, all state changes on its rising edge
//   reset      : asynchronous active-low reset
//   start      : request a run (sampled only in IDLE)
//   challenge  : LFSR seed, captured when start is accepted
//   ro_in      : raw ring-oscillator outputs, asynchronous to clock
//   ro_en      : ring-oscillator enables (the selected pair in SETTLE/COUNT)
//   ack        : consumer has read the response (sampled only in DONE)
//   response   : result of the last completed run
//   valid      : response ready, high exactly while in DONE
//   busy       : high in every state except IDLE
//   tie_cnt    : saturating count of tied comparisons in the last run
// -----------------------------------------------------------------------------
module puf_serial_vote #(
    parameter int RESP_W = 8,
    parameter int N_RO   = 32,
    parameter int WINDOW = 1024,
    parameter int CNT_W  = 16,
    parameter int VOTES  = 3,
    parameter logic [2*$clog2(N_RO/2)-1:0] TAPS = 8'hB8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    input  logic [2*$clog2(N_RO/2)-1:0]   challenge,
    input  logic [N_RO-1:0]               ro_in,
    output logic [N_RO-1:0]               ro_en,
    input  logic                          ack,
    output logic [RESP_W-1:0]             response,
    output logic                          valid,
    output logic                          busy,
    output logic [7:0]                    tie_cnt
);

    localparam int SEL_W  = $clog2(N_RO/2);
    localparam int LFSR_W = 2*SEL_W;
    localparam int CYC_W  = $clog2(WINDOW);
    localparam int VI_W   = (VOTES > 1) ? $clog2(VOTES) : 1;
    localparam int ONES_W = $clog2(VOTES+1);
    localparam int BI_W   = (RESP_W > 1) ? $clog2(RESP_W) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETTLE  = 3'd1,
        S_COUNT   = 3'd2,
        S_COMPARE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic [LFSR_W-1:0] lfsr;
    logic [CYC_W-1:0]  cyc;
    logic [BI_W-1:0]   bit_idx;
    logic [VI_W-1:0]   vote_idx;
    logic [ONES_W-1:0] ones;
    logic [RESP_W-1:0] result;
    logic [CNT_W-1:0]  cnt_a, cnt_b;

    // Synchronizer and edge-detect flops for the two selected oscillators
    logic sync_a_p0, sync_a_p1, prev_a_p2;
    logic sync_b_p0, sync_b_p1, prev_b_p2;

    // Combinational decode
    logic [SEL_W-1:0]  sel_a, sel_b;
    logic [SEL_W:0]    idx_a, idx_b;
    logic              edge_a, edge_b;
    logic              last_settle, last_count, last_vote, last_bit;
    logic              vote_bit, tie;
    logic [ONES_W-1:0] ones_nxt;
    logic              bit_val;
    logic [RESP_W-1:0] result_nxt;

    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [7:0] sat_inc_tie(input logic [7:0] v);
        return (&v) ? v : v + 8'd1;
    endfunction

    // Galois step: shift right, fold TAPS back in when a 1 falls out
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
        return (v >> 1) ^ (v[0] ? TAPS : '0);
    endfunction

    assign sel_a = lfsr[SEL_W-1:0];
    assign sel_b = lfsr[LFSR_W-1:SEL_W];
    // N_RO/2 is a power of two, so bank B's index is just the MSB set
    assign idx_a = {1'b0, sel_a};
    assign idx_b = {1'b1, sel_b};

    assign edge_a = sync_a_p1 & ~prev_a_p2;
    assign edge_b = sync_b_p1 & ~prev_b_p2;

    assign last_settle = (cyc == CYC_W'(3));
    assign last_count  = (cyc == CYC_W'(WINDOW-1));
    assign last_vote   = (vote_idx == VI_W'(VOTES-1));
    assign last_bit    = (bit_idx == BI_W'(RESP_W-1));

    // Ties vote 0 and are tallied separately
    assign vote_bit = (cnt_a > cnt_b);
    assign tie      = (cnt_a == cnt_b);
    assign ones_nxt = ones + ONES_W'(vote_bit);
    assign bit_val  = (ones_nxt > ONES_W'(VOTES/2));

    always_comb begin
        result_nxt          = result;
        result_nxt[bit_idx] = bit_val;
    end

    assign busy  = (state != S_IDLE);
    assign valid = (state == S_DONE);

    always_comb begin
        ro_en = '0;
        if (state == S_SETTLE || state == S_COUNT) begin
            ro_en[idx_a] = 1'b1;
            ro_en[idx_b] = 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start) state_nxt = S_SETTLE;
            S_SETTLE:  if (last_settle) state_nxt = S_COUNT;
            S_COUNT:   if (last_count) state_nxt = S_COMPARE;
            S_COMPARE: state_nxt = (last_vote && last_bit) ? S_DONE : S_SETTLE;
            S_DONE:    if (ack) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_a_p0 <= 1'b0;
            sync_a_p1 <= 1'b0;
            prev_a_p2 <= 1'b0;
            sync_b_p0 <= 1'b0;
            sync_b_p1 <= 1'b0;
            prev_b_p2 <= 1'b0;
        end else begin
            // p0 -> p1: two-flop synchronizer
            sync_a_p0 <= ro_in[idx_a];
            sync_b_p0 <= ro_in[idx_b];
            sync_a_p1 <= sync_a_p0;
            sync_b_p1 <= sync_b_p0;
            // p2: previous synchronized level for edge detection
            prev_a_p2 <= sync_a_p1;
            prev_b_p2 <= sync_b_p1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lfsr     <= '0;
            cyc      <= '0;
            bit_idx  <= '0;
            vote_idx <= '0;
            ones     <= '0;
            result   <= '0;
            response <= '0;
            tie_cnt  <= '0;
            cnt_a    <= '0;
            cnt_b    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        lfsr     <= (challenge == '0) ? LFSR_W'(1) : challenge;
                        cyc      <= '0;
                        bit_idx  <= '0;
                        vote_idx <= '0;
                        ones     <= '0;
                        tie_cnt  <= '0;
                        cnt_a    <= '0;
                        cnt_b    <= '0;
                    end
                end
                S_SETTLE: begin
                    // Edges seen here only refill the synchronizer; not counted
                    cyc <= last_settle ? '0 : cyc + 1'b1;
                end
                S_COUNT: begin
                    cyc <= last_count ? '0 : cyc + 1'b1;
                    if (edge_a) cnt_a <= sat_inc_cnt(cnt_a);
                    if (edge_b) cnt_b <= sat_inc_cnt(cnt_b);
                end
                S_COMPARE: begin
                    // Counters clear here so every SETTLE entry starts from zero
                    cnt_a <= '0;
                    cnt_b <= '0;
                    if (tie) tie_cnt <= sat_inc_tie(tie_cnt);
                    if (!last_vote) begin
                        vote_idx <= vote_idx + 1'b1;
                        ones     <= ones_nxt;
                    end else begin
                        result   <= result_nxt;
                        lfsr     <= lfsr_step(lfsr);
                        vote_idx <= '0;
                        ones     <= '0;
                        if (last_bit) response <= result_nxt;
                        else          bit_idx  <= bit_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_puf_serial_vote.sv
module tb_puf_serial_vote;

    localparam int RESP_W = 8;
    localparam int N_RO   = 32;
    localparam int WINDOW = 64;
    localparam int VOTES  = 3;
    localparam int BIT_CYC = VOTES * (WINDOW + 5);      // 207
    localparam int RUN_CYC = RESP_W * BIT_CYC;          // 1656

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic [7:0]        challenge = 8'h00;
    logic [N_RO-1:0]   ro_in = '0;
    logic [N_RO-1:0]   ro_en;
    logic              ack = 1'b0;
    logic [RESP_W-1:0] response;
    logic              valid;
    logic              busy;
    logic [7:0]        tie_cnt;

    int errors = 0;
    int checks = 0;
    int mode = 0;           // 0: bank A fast, 1: bank B fast, 2: all equal
    logic [7:0] pc = 8'h00;

    puf_serial_vote #(
        .RESP_W(RESP_W), .N_RO(N_RO), .WINDOW(WINDOW),
        .CNT_W(16), .VOTES(VOTES), .TAPS(8'hB8)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .challenge(challenge),
        .ro_in(ro_in), .ro_en(ro_en), .ack(ack), .response(response),
        .valid(valid), .busy(busy), .tie_cnt(tie_cnt)
    );

    always #5 clock = ~clock;

    // Oscillator model: pc[1] toggles with period 4 clocks, pc[2] with period 8
    always @(negedge clock) begin
        pc = pc + 8'd1;
        case (mode)
            0:       ro_in = {{16{pc[2]}}, {16{pc[1]}}};
            1:       ro_in = {{16{pc[1]}}, {16{pc[2]}}};
            default: ro_in = {32{pc[2]}};
        endcase
    end

    typedef struct {
        logic [7:0] chal;
        int         md;
        logic [7:0] exp_resp;
        logic [7:0] exp_tie;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Accept a start, then count edges until valid rises (bounded)
    task automatic run_to_valid(input logic [7:0] chal, output int lat);
        challenge = chal;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!valid && lat < 3000);
    endtask

    task automatic do_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    logic [7:0]      lfsr_m;
    logic [N_RO-1:0] exp_en;
    int              lat;
    int              n;

    initial begin
        vecs[0] = '{chal: 8'h5A, md: 0, exp_resp: 8'hFF, exp_tie: 8'd0};
        vecs[1] = '{chal: 8'h5A, md: 1, exp_resp: 8'h00, exp_tie: 8'd0};
        vecs[2] = '{chal: 8'h3C, md: 2, exp_resp: 8'h00, exp_tie: 8'd24};
        vecs[3] = '{chal: 8'hA5, md: 0, exp_resp: 8'hFF, exp_tie: 8'd0};

        // Reset state
        #1;
        check("rst_valid", 64'(valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_ro_en", 64'(ro_en), 64'(0));
        check("rst_response", 64'(response), 64'(0));
        check("rst_tie", 64'(tie_cnt), 64'(0));
        tick();
        tick();
        reset = 1'b1;
        tick();

        // Table-driven full runs
        for (int i = 0; i < 4; i++) begin
            mode = vecs[i].md;
            run_to_valid(vecs[i].chal, lat);
            check($sformatf("latency[%0d]", i), 64'(lat), 64'(RUN_CYC));
            check($sformatf("response[%0d]", i), 64'(response), 64'(vecs[i].exp_resp));
            check($sformatf("tie_cnt[%0d]", i), 64'(tie_cnt), 64'(vecs[i].exp_tie));
            check($sformatf("busy_done[%0d]", i), 64'(busy), 64'(1));
            do_ack();
            check($sformatf("idle_after_ack[%0d]", i), 64'(busy), 64'(0));
        end

        // Zero challenge: LFSR seeded with 1, enable pattern follows the model
        mode = 0;
        lfsr_m = 8'h01;
        challenge = 8'h00;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
            if (n == 1) check("first_ro_en", 64'(ro_en), 64'h0000_0000_0001_0002);
            for (int k = 0; k < RESP_W; k++) begin
                if (n == k * BIT_CYC + 1) begin
                    exp_en = '0;
                    exp_en[lfsr_m[3:0]] = 1'b1;
                    exp_en[16 + lfsr_m[7:4]] = 1'b1;
                    check($sformatf("lfsr_ro_en[%0d]", k), 64'(ro_en), 64'(exp_en));
                    lfsr_m = (lfsr_m >> 1) ^ (lfsr_m[0] ? 8'hB8 : 8'h00);
                end
            end
        end while (!valid && n < 3000);
        check("lfsr_latency", 64'(n), 64'(RUN_CYC));
        check("lfsr_response", 64'(response), 64'hFF);

        // Ack withheld for 10 cycles while start is pulsed
        for (int i = 0; i < 10; i++) begin
            start = (i % 3 == 0);
            tick();
            check($sformatf("hold_valid[%0d]", i), 64'(valid), 64'(1));
            check($sformatf("hold_resp[%0d]", i), 64'(response), 64'hFF);
        end
        start = 1'b0;
        check("hold_ro_en", 64'(ro_en), 64'(0));
        // ack with start in the same cycle: start must be ignored
        ack = 1'b1;
        start = 1'b1;
        tick();
        ack = 1'b0;
        start = 1'b0;
        check("ack_busy", 64'(busy), 64'(0));
        check("ack_valid", 64'(valid), 64'(0));
        tick();
        check("ack_no_run_busy", 64'(busy), 64'(0));
        check("ack_no_run_ro_en", 64'(ro_en), 64'(0));

        // Reset pulsed low in COUNT of bit 3 of a mode-2 run
        mode = 2;
        challenge = 8'h77;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3 * BIT_CYC + 30; i++) tick();
        check("pre_rst_busy", 64'(busy), 64'(1));
        check("pre_rst_ro_en_nz", 64'(ro_en != '0), 64'(1));
        reset = 1'b0;
        #1;
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_valid", 64'(valid), 64'(0));
        check("mid_rst_ro_en", 64'(ro_en), 64'(0));
        check("mid_rst_response", 64'(response), 64'(0));
        check("mid_rst_tie", 64'(tie_cnt), 64'(0));
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("post_rst_idle", 64'(busy), 64'(0));
        mode = 0;
        run_to_valid(8'h5A, lat);
        check("post_rst_latency", 64'(lat), 64'(RUN_CYC));
        check("post_rst_response", 64'(response), 64'hFF);
        check("post_rst_tie", 64'(tie_cnt), 64'(0));
        do_ack();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/puf_serial_vote.md
PUF_SERIAL_VOTE -- requirements
Module: puf_serial_vote

Interface
REQ-001 SHALL have parameter RESP_W, default 8: number of response bits per run.
REQ-002 SHALL have parameter N_RO, default 32: total ring-oscillator inputs, split into bank A = [N_RO/2-1:0] and bank B = [N_RO-1:N_RO/2]; N_RO/2 is a power of 2; SEL_W = log2(N_RO/2).
REQ-003 SHALL have parameter WINDOW, default 1024: counting window in clock cycles, ≥ 4.
REQ-004 SHALL have parameter CNT_W, default 16: edge-counter width.
REQ-005 SHALL have parameter VOTES, default 3: comparisons per response bit; odd and ≥ 1.
REQ-006 SHALL have parameter TAPS, default 8'hB8: Galois LFSR feedback mask, width 2*SEL_W.
REQ-007 clock  input  1  system clock; all state changes on its rising edge.
REQ-008 reset  input  1  asynchronous, active-low reset.
REQ-009 start  input  1  request a run; sampled only in IDLE.
REQ-010 challenge  input  2*SEL_W  LFSR seed, captured when start is accepted.
REQ-011 ro_in  input  N_RO  raw ring-oscillator outputs, asynchronous to clock.
REQ-012 ro_en  output  N_RO  ring-oscillator enables.
REQ-013 ack  input  1  consumer has read response; sampled only in DONE.
REQ-014 response  output  RESP_W  result of the last completed run.
REQ-015 valid  output  1  response ready; held until ack.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 tie_cnt  output  8  saturating count of tied comparisons in the last run.

Function
REQ-018 SHALL implement the states IDLE, SETTLE (4 cycles), COUNT (WINDOW cycles), COMPARE (1 cycle) and DONE.
REQ-019 IDLE with start=1 SHALL perform all of the following on that edge: go to SETTLE; load the LFSR with challenge (all-zero loaded as 1); clear the bit index, vote index, ones count and tie_cnt.
REQ-020 sel_a = lfsr[SEL_W-1:0] and sel_b = lfsr[2*SEL_W-1:SEL_W] SHALL select ro_in[sel_a] and ro_in[N_RO/2+sel_b].
REQ-021 ro_en SHALL have exactly bits sel_a and N_RO/2+sel_b high in SETTLE and COUNT, and SHALL be all zero otherwise.
REQ-022 Both selected signals SHALL pass through a 2-flop synchronizer followed by a rising-edge detect flop; SETTLE flushes these flops.
REQ-023 Counters cnt_a and cnt_b SHALL clear on SETTLE entry, increment once per detected rising edge during COUNT only, and saturate at 2^CNT_W-1.
REQ-024 COMPARE SHALL treat cnt_a > cnt_b as a vote of 1 and cnt_a < cnt_b as a vote of 0.
REQ-025 COMPARE with cnt_a == cnt_b SHALL treat the result as a vote of 0 and SHALL increment tie_cnt, saturating at 255.
REQ-026 After COMPARE, if the vote index < VOTES-1, the block SHALL increment the vote index and return to SETTLE with the same selection.
REQ-027 After the last vote of a bit, the bit SHALL be (ones > VOTES/2); bit k SHALL be written to the internal result[k].
REQ-028 After the last vote of a bit, the LFSR SHALL step once (shift right; XOR TAPS if the shifted-out bit is 1), and the vote index and ones count SHALL clear.
REQ-029 After the last vote of bit RESP_W-1, the block SHALL go to DONE and load response from result; response SHALL be unchanged at all other times.
REQ-030 valid SHALL be high exactly while in DONE; it SHALL rise RESP_W*VOTES*(WINDOW+5) edges after the edge that accepted start.
REQ-031 DONE with ack=1 SHALL go to IDLE on that edge; DONE with ack=0 SHALL hold valid and response indefinitely.
REQ-032 start SHALL be ignored outside IDLE, including the cycle in which ack is accepted; ack SHALL be ignored outside DONE.
REQ-033 Accurate counts require a ring-oscillator frequency below clock/2; faster inputs undercount but SHALL NOT corrupt the FSM.

Reset
REQ-034 While reset=0, state SHALL be IDLE and response, valid, busy, ro_en, tie_cnt, the counters, the LFSR and the synchronizers SHALL all be 0, asynchronously.
REQ-035 Reset asserted mid-run SHALL abort the run with no partial response; the first start after reset release SHALL begin a clean run.

Verification (RESP_W=8, N_RO=32, WINDOW=64, VOTES=3)
REQ-036 All bank-A ro_in toggle with period 4 clocks and all bank-B with period 8; challenge=8'h5A -> response=8'hFF, tie_cnt=0, valid rises 1656 edges after start.
REQ-037 The banks swapped -> response=8'h00, tie_cnt=0.
REQ-038 All ro_in with equal period 8 and phase -> response=8'h00, tie_cnt=24.
REQ-039 challenge=8'h00 -> the first ro_en is 32'h0001_0002 (sel_a=1, sel_b=0); the LFSR sequence from seed 1 matches a reference model for all 8 bits.
REQ-040 reset pulsed low in COUNT of bit 3 -> all outputs 0 immediately; a new start yields the full 1656-cycle run.
REQ-041 ack withheld for 10 cycles in DONE with start pulsed -> valid and response stable and no new run; ack=1 -> IDLE and busy=0 on the next cycle.
